// File: rtl/pi_sample_sched.sv
// pi_sample_sched: periodic sampler and sequencer in front of the PI stage.
// Forms the saturated error ek = sat(ref_in - fb_in), keeps the previous error
// and output, pulses pista, waits PI_LAT cycles, then commits uk_in.
// Optional: define ERR_DEADBAND_EN to add the `deadband` input, which zeroes
// ek when the magnitude of the saturated error is within the deadband.
//
// state  | meaning
// IDLE   | sampling disabled
// WAIT   | enabled, waiting for the period tick
// SAMPLE | register ek / ek_ex
// START  | pista high for one cycle
// RUN    | PI computing, PI_LAT cycles
// COMMIT | capture uk_in into uk_ex / uk_out
module pi_sample_sched #(
    parameter int WIDTH  = 32,
    parameter int CNT_W  = 16,
    parameter int PI_LAT = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] period,
    input  logic [WIDTH-1:0] ref_in,
    input  logic [WIDTH-1:0] fb_in,
    input  logic [WIDTH-1:0] uk_in,
    input  logic             ovr_clr,
`ifdef ERR_DEADBAND_EN
    input  logic [WIDTH-1:0] deadband,
`endif
    output logic             pista,
    output logic [WIDTH-1:0] ek,
    output logic [WIDTH-1:0] ek_ex,
    output logic [WIDTH-1:0] uk_ex,
    output logic [WIDTH-1:0] uk_out,
    output logic             uk_valid,
    output logic             busy,
    output logic             overrun
);

    localparam int RUN_W = (PI_LAT > 1) ? $clog2(PI_LAT + 1) : 1;
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_SAMPLE,
        S_START,
        S_RUN,
        S_COMMIT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] per_m1;
    logic             tick;
    logic [RUN_W-1:0] run_cnt;
    logic             first;
    logic             en_d;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] sat;
    logic [WIDTH-1:0] ek_next;
`ifdef ERR_DEADBAND_EN
    logic [WIDTH-1:0] mag;
`endif

    // Terminal count of the period counter; a period of 0 behaves like 1.
    always_comb begin
        per_m1 = (period == '0) ? '0 : period - CNT_W'(1);
        tick   = en && (cnt == per_m1);
    end

    // Period counter; wraps on >= so a shrunken period takes effect at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (!en || cnt >= per_m1)
            cnt <= '0;
        else
            cnt <= cnt + CNT_W'(1);
    end

    // Saturating subtraction in WIDTH+1 bits, optional deadband on the result.
    always_comb begin
        diff = {ref_in[WIDTH-1], ref_in} - {fb_in[WIDTH-1], fb_in};
        if (diff[WIDTH] != diff[WIDTH-1])
            sat = diff[WIDTH] ? SAT_MIN : SAT_MAX;
        else
            sat = diff[WIDTH-1:0];
`ifdef ERR_DEADBAND_EN
        if (sat == SAT_MIN)
            mag = SAT_MAX;
        else if (sat[WIDTH-1])
            mag = -sat;
        else
            mag = sat;
        ek_next = (mag <= deadband) ? '0 : sat;
`else
        ek_next = sat;
`endif
    end

    // Sequencer FSM with registered outputs and sticky overrun flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            run_cnt  <= '0;
            first    <= 1'b1;
            en_d     <= 1'b0;
            pista    <= 1'b0;
            ek       <= '0;
            ek_ex    <= '0;
            uk_ex    <= '0;
            uk_out   <= '0;
            uk_valid <= 1'b0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            en_d     <= en;
            pista    <= 1'b0;
            uk_valid <= 1'b0;
            if (en && !en_d)
                first <= 1'b1;
            // A tick while a sequence is in flight is lost; set beats clear.
            if (tick && state != S_IDLE && state != S_WAIT)
                overrun <= 1'b1;
            else if (ovr_clr)
                overrun <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (en)
                        state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!en) begin
                        state <= S_IDLE;
                    end else if (tick) begin
                        state <= S_SAMPLE;
                        busy  <= 1'b1;
                    end
                end
                S_SAMPLE: begin
                    ek    <= ek_next;
                    ek_ex <= first ? '0 : ek;
                    first <= 1'b0;
                    pista <= 1'b1;
                    state <= S_START;
                end
                S_START: begin
                    run_cnt <= RUN_W'(PI_LAT - 1);
                    state   <= S_RUN;
                end
                S_RUN: begin
                    if (run_cnt == '0)
                        state <= S_COMMIT;
                    else
                        run_cnt <= run_cnt - RUN_W'(1);
                end
                S_COMMIT: begin
                    uk_ex    <= uk_in;
                    uk_out   <= uk_in;
                    uk_valid <= 1'b1;
                    busy     <= 1'b0;
                    state    <= en ? S_WAIT : S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pi_sample_sched.sv
// Testbench for pi_sample_sched: directed sequence, scoreboard of expected
// samples checked at uk_valid, mock PI stage with a PI_LAT-cycle latency.
module tb_pi_sample_sched;

    localparam int WIDTH  = 32;
    localparam int CNT_W  = 16;
    localparam int PI_LAT = 5;
    localparam logic [31:0] GARB = 32'hBAD0_BAD0;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [CNT_W-1:0] period;
    logic [WIDTH-1:0] ref_in;
    logic [WIDTH-1:0] fb_in;
    logic [WIDTH-1:0] uk_in = GARB;
    logic             ovr_clr;
    logic [WIDTH-1:0] deadband = '0;
    logic             pista;
    logic [WIDTH-1:0] ek;
    logic [WIDTH-1:0] ek_ex;
    logic [WIDTH-1:0] uk_ex;
    logic [WIDTH-1:0] uk_out;
    logic             uk_valid;
    logic             busy;
    logic             overrun;

    pi_sample_sched #(.WIDTH(WIDTH), .CNT_W(CNT_W), .PI_LAT(PI_LAT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .period   (period),
        .ref_in   (ref_in),
        .fb_in    (fb_in),
        .uk_in    (uk_in),
        .ovr_clr  (ovr_clr),
`ifdef ERR_DEADBAND_EN
        .deadband (deadband),
`endif
        .pista    (pista),
        .ek       (ek),
        .ek_ex    (ek_ex),
        .uk_ex    (uk_ex),
        .uk_out   (uk_out),
        .uk_valid (uk_valid),
        .busy     (busy),
        .overrun  (overrun)
    );

    typedef struct {
        logic [31:0] ek;
        logic [31:0] ek_ex;
        logic [31:0] uk;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          pq[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic        m_first;
    logic [31:0] m_prev_ek;
    logic [31:0] m_uk_ex;
    int          pi_cnt = 0;
    logic [31:0] pi_res = '0;
    exp_t        got;
    int          due_p;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Mock PI stage: result settles PI_LAT edges after the edge sampling pista.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pi_cnt <= 0;
            uk_in  <= GARB;
        end else if (pi_cnt != 0) begin
            pi_cnt <= pi_cnt - 1;
            if (pi_cnt == 1)
                uk_in <= pi_res;
        end else if (pista) begin
            pi_cnt <= PI_LAT;
            pi_res <= uk_ex + ek + 32'd1174;
            uk_in  <= GARB;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
        longint d;
        d = longint'($signed(a)) - longint'($signed(b));
        if (d > 64'sd2147483647)
            return 32'h7FFF_FFFF;
        if (d < -64'sd2147483648)
            return 32'h8000_0000;
        return d[31:0];
    endfunction

    function automatic logic [31:0] apply_db(input logic [31:0] s, input logic [31:0] db);
        logic [31:0] mag;
        if (s == 32'h8000_0000)
            mag = 32'h7FFF_FFFF;
        else if (s[31])
            mag = -s;
        else
            mag = s;
        return (mag <= db) ? 32'h0 : s;
    endfunction

    // Drive one sample's inputs and queue its expected pista and commit.
    task automatic sample(input int t_tick, input logic [31:0] r, input logic [31:0] f);
        exp_t        e;
        logic [31:0] k;
        ref_in = r;
        fb_in  = f;
        k = sat_sub(r, f);
`ifdef ERR_DEADBAND_EN
        k = apply_db(k, deadband);
`endif
        e.ek    = k;
        e.ek_ex = m_first ? 32'h0 : m_prev_ek;
        e.uk    = m_uk_ex + k + 32'd1174;
        e.due   = t_tick + 4 + PI_LAT;
        m_first   = 1'b0;
        m_prev_ek = k;
        m_uk_ex   = e.uk;
        sb.push_back(e);
        pq.push_back(t_tick + 2);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // pista monitor: each pulse must match the next expected cycle.
    always @(negedge clk) begin
        if (pista) begin
            if (pq.size() == 0) begin
                check("pista_spurious", pista, 0);
            end else begin
                due_p = pq.pop_front();
                check("pista_cycle", cyc, due_p);
            end
        end else if (pq.size() != 0 && cyc > pq[0]) begin
            check("pista_missing", pista, 1);
            void'(pq.pop_front());
        end
    end

    // uk_valid monitor: pops the scoreboard and compares the committed sample.
    always @(negedge clk) begin
        if (uk_valid) begin
            if (sb.size() == 0) begin
                check("ukv_spurious", uk_valid, 0);
            end else begin
                got = sb.pop_front();
                check("ukv_cycle", cyc, got.due);
                check("uk_out", uk_out, got.uk);
                check("uk_ex", uk_ex, got.uk);
                check("ek", ek, got.ek);
                check("ek_ex", ek_ex, got.ek_ex);
            end
        end else if (sb.size() != 0 && cyc > sb[0].due) begin
            check("ukv_missing", uk_valid, 1);
            void'(sb.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, e1, e2, t0, r, tk, tl;
        rst_n = 1'b0; en = 1'b0; period = 16'd20;
        ref_in = '0; fb_in = '0; ovr_clr = 1'b0;
        m_first = 1'b1; m_prev_ek = '0; m_uk_ex = '0;
        repeat (3) @(negedge clk);
        check("rst_pista", pista, 0);
        check("rst_ek", ek, 0);
        check("rst_ek_ex", ek_ex, 0);
        check("rst_uk_ex", uk_ex, 0);
        check("rst_uk_out", uk_out, 0);
        check("rst_uk_valid", uk_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // First/second sample, saturation both ways, then disable during RUN.
        e0 = cyc; en = 1'b1;
        sample(e0 + 19, 32'd100, 32'd40);
        wait_until(e0 + 30); sample(e0 + 39, 32'd100, 32'd70);
        wait_until(e0 + 50); sample(e0 + 59, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
        wait_until(e0 + 70); sample(e0 + 79, 32'h8000_0000, 32'd1);
        wait_until(e0 + 90); sample(e0 + 99, 32'hFFFF_FFFB, 32'd20);
        wait_until(e0 + 103); en = 1'b0;
        wait_until(e0 + 107); check("busy_commit", busy, 1);
        wait_until(e0 + 109);
        check("busy_after_disable", busy, 0);
        check("overrun_slow", overrun, 0);
        period = 16'd9;
        wait_until(e0 + 130);
        check("busy_idle", busy, 0);

        // Minimum loss-free period for 100 periods; re-enable restarts ek_ex.
        e1 = cyc; en = 1'b1; m_first = 1'b1;
        for (int k = 0; k < 100; k++) begin
            tk = e1 + 8 + 9 * k;
            wait_until(tk - 3);
            sample(tk, 32'd50, 32'(k * 7 - 100));
        end
        tl = e1 + 8 + 9 * 99;
        wait_until(tl + 3); en = 1'b0;
        wait_until(tl + 12);
        check("overrun_p9", overrun, 0);
        check("busy_p9_end", busy, 0);

        // Period 4: two of every three ticks are dropped.
        period = 16'd4;
        e2 = cyc; en = 1'b1; m_first = 1'b1; t0 = e2 + 3;
        for (int j = 0; j < 4; j++)
            sample(t0 + 12 * j, 32'hFFFF_FF9C, 32'hFFFF_FED4);
        wait_until(t0 + 4);  check("ovr_before_drop", overrun, 0);
        wait_until(t0 + 5);  check("ovr_set", overrun, 1);
        wait_until(t0 + 25); ovr_clr = 1'b1;
        wait_until(t0 + 26); ovr_clr = 1'b0;
        check("ovr_cleared", overrun, 0);
        wait_until(t0 + 28); check("ovr_still_clear", overrun, 0);
        wait_until(t0 + 29); check("ovr_reset", overrun, 1);
        wait_until(t0 + 40); ovr_clr = 1'b1;
        wait_until(t0 + 41); ovr_clr = 1'b0;
        check("ovr_set_wins", overrun, 1);

        // Reset in the middle of RUN of the next sampled tick.
        pq.push_back(t0 + 50);
        wait_until(t0 + 53);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_pista", pista, 0);
        check("mid_rst_ek", ek, 0);
        check("mid_rst_ek_ex", ek_ex, 0);
        check("mid_rst_uk_ex", uk_ex, 0);
        check("mid_rst_uk_out", uk_out, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_overrun", overrun, 0);
        m_first = 1'b1; m_prev_ek = '0; m_uk_ex = '0;
        wait_until(t0 + 55);
        #2 rst_n = 1'b1;
        r = cyc;
        sample(r + 3, 32'd7, 32'd3);
        wait_until(r + 6); en = 1'b0;
        wait_until(r + 20);

`ifdef ERR_DEADBAND_EN
        period = 16'd20; deadband = 32'd10;
        e0 = cyc; en = 1'b1; m_first = 1'b1;
        sample(e0 + 19, 32'd105, 32'd100);
        wait_until(e0 + 30); sample(e0 + 39, 32'd111, 32'd100);
        wait_until(e0 + 42); en = 1'b0;
        wait_until(e0 + 55);
`endif

        check("sb_drained", sb.size(), 0);
        check("pq_drained", pq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
